// File: rtl/counter_load_deser_if.sv
// Serial load bus between the serial source and the counter load front end.
// The master drives the serial bit stream and receives the load bus and status.
// The slave (counter_load_deser) receives the serial stream and drives the load bus.
interface counter_load_deser_if #(
  parameter int DATA_W = 8
);

  logic              sin_start;
  logic              sin_valid;
  logic              sin_bit;
  logic [DATA_W-1:0] wdata;
  logic              wr;
  logic              busy;
  logic              frame_err;
  logic [7:0]        frame_cnt;

  modport master (
    output sin_start, sin_valid, sin_bit,
    input  wdata, wr, busy, frame_err, frame_cnt
  );

  modport slave (
    input  sin_start, sin_valid, sin_bit,
    output wdata, wr, busy, frame_err, frame_cnt
  );

endinterface

// File: rtl/counter_load_deser.sv
// Serial-to-parallel load front end for the 8-bit loadable counter.
// Collects one MSB-first serial frame per load, then drives the counter's
// load bus (wdata) together with a single-cycle write strobe (wr).
// Aborted frames (restart or inter-bit timeout) pulse frame_err; committed
// loads are counted in frame_cnt.
// Optional feature macro: PARITY_CHECK_EN -- appends one even-parity bit to
// every frame and rejects frames whose parity does not check.
module counter_load_deser #(
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 16
) (
  input logic                 clk,
  input logic                 reset,
  counter_load_deser_if.slave bus
);

`ifdef PARITY_CHECK_EN
  localparam int FRAME_LEN = DATA_W + 1;
`else
  localparam int FRAME_LEN = DATA_W;
`endif
  localparam int CNT_W = $clog2(DATA_W + 2);
  localparam int TMR_W = $clog2(TIMEOUT + 1);

  localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(FRAME_LEN - 1);
  localparam logic [TMR_W-1:0] TMR_LIMIT = TMR_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    COMMIT
  } state_e;

  state_e            state_q,     state_d;
  logic [DATA_W-1:0] shreg_q,     shreg_d;
  logic [CNT_W-1:0]  bit_cnt_q,   bit_cnt_d;
  logic [TMR_W-1:0]  idle_tmr_q,  idle_tmr_d;
  logic [DATA_W-1:0] wdata_q,     wdata_d;
  logic              wr_q,        wr_d;
  logic              frame_err_q, frame_err_d;
  logic [7:0]        frame_cnt_q, frame_cnt_d;

  logic [DATA_W-1:0] shreg_shifted;
  assign shreg_shifted = {shreg_q[DATA_W-2:0], bus.sin_bit};

  // Next-state and registered-output logic for the frame collector FSM.
  always_comb begin
    // NOTE: every variable gets a default before any branch so no path can
    // leave it unassigned and infer a latch.
    state_d     = state_q;
    shreg_d     = shreg_q;
    bit_cnt_d   = bit_cnt_q;
    idle_tmr_d  = idle_tmr_q;
    wdata_d     = wdata_q;
    wr_d        = 1'b0;
    frame_err_d = 1'b0;
    frame_cnt_d = frame_cnt_q;

    unique case (state_q)
      IDLE: begin
        // sin_valid alone is ignored; the start cycle never carries a data bit.
        if (bus.sin_start) begin
          state_d    = SHIFT;
          bit_cnt_d  = '0;
          idle_tmr_d = '0;
        end
      end

      SHIFT: begin
        if (bus.sin_start) begin
          // A restart wins over any bit in the same cycle, including the last.
          frame_err_d = 1'b1;
          bit_cnt_d   = '0;
          idle_tmr_d  = '0;
        end else if (bus.sin_valid) begin
          idle_tmr_d = '0;
          bit_cnt_d  = bit_cnt_q + 1'b1;
`ifdef PARITY_CHECK_EN
          if (bit_cnt_q == LAST_BIT) begin
            // Trailing bit is parity: it is checked against the data, never stored.
            if (^{shreg_q, bus.sin_bit}) begin
              frame_err_d = 1'b1;
              state_d     = IDLE;
            end else begin
              state_d = COMMIT;
            end
          end else begin
            shreg_d = shreg_shifted;
          end
`else
          shreg_d = shreg_shifted;
          if (bit_cnt_q == LAST_BIT) begin
            state_d = COMMIT;
          end
`endif
        end else if (idle_tmr_q == TMR_LIMIT) begin
          // This idle cycle brings the gap to TIMEOUT: abandon the frame.
          frame_err_d = 1'b1;
          idle_tmr_d  = '0;
          state_d     = IDLE;
        end else begin
          idle_tmr_d = idle_tmr_q + 1'b1;
        end
      end

      COMMIT: begin
        // Single cycle; serial inputs are ignored while the load is issued.
        wr_d        = 1'b1;
        wdata_d     = shreg_q;
        frame_cnt_d = frame_cnt_q + 8'd1;
        state_d     = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset discards any partial frame silently.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      shreg_q     <= '0;
      bit_cnt_q   <= '0;
      idle_tmr_q  <= '0;
      wdata_q     <= '0;
      wr_q        <= 1'b0;
      frame_err_q <= 1'b0;
      frame_cnt_q <= 8'd0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      bit_cnt_q   <= bit_cnt_d;
      idle_tmr_q  <= idle_tmr_d;
      wdata_q     <= wdata_d;
      wr_q        <= wr_d;
      frame_err_q <= frame_err_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign bus.wdata     = wdata_q;
  assign bus.wr        = wr_q;
  assign bus.busy      = (state_q == SHIFT);
  assign bus.frame_err = frame_err_q;
  assign bus.frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_counter_load_deser.sv
// Self-checking bench for counter_load_deser.
// Frames are described at transaction level (value, gaps, aborts); the
// reference model tracks expected loads, errors, frame count and last load
// value from the frame rules alone. A negedge monitor counts wr/frame_err
// pulses and watches pulse spacing and overlap.
// Build with +define+PARITY_CHECK_EN to exercise the parity variant.
module tb_counter_load_deser;

  localparam int DATA_W  = 8;
  localparam int TIMEOUT = 16;
`ifdef PARITY_CHECK_EN
  localparam bit PARITY = 1'b1;
`else
  localparam bit PARITY = 1'b0;
`endif
  localparam int FRAME_LEN = DATA_W + (PARITY ? 1 : 0);

  logic clk   = 1'b0;
  logic reset = 1'b1;

  counter_load_deser_if #(.DATA_W(DATA_W)) bus ();

  counter_load_deser #(
    .DATA_W (DATA_W),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Monitor observations
  int         wr_seen     = 0;
  int         err_seen    = 0;
  int         overlap     = 0;
  int         spacing_bad = 0;
  int         since_wr    = 1000;

  // Reference model state
  int         exp_loads = 0;
  int         exp_err   = 0;
  int         exp_cnt   = 0;
  logic [7:0] exp_wdata = 8'h00;
  bit         in_frame  = 1'b0;

  // Pulse monitor, sampled away from the active edge.
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.wr) begin
        wr_seen++;
        if (since_wr < DATA_W + 2) spacing_bad++;
        since_wr = 0;
      end else if (since_wr < 1000) begin
        since_wr++;
      end
      if (bus.frame_err) err_seen++;
      if (bus.wr && bus.frame_err) overlap++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs set here take effect at the next rising edge.
  task automatic cycle(input logic st, input logic v, input logic b);
    @(negedge clk);
    #1;
    bus.sin_start = st;
    bus.sin_valid = v;
    bus.sin_bit   = b;
  endtask

  task automatic idle(input int n);
    repeat (n) cycle(1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_start(input logic v);
    if (in_frame) exp_err++;
    cycle(1'b1, v, 1'($urandom));
    in_frame = 1'b1;
  endtask

  task automatic do_bit(input logic b, input int gap);
    repeat (gap) cycle(1'b0, 1'b0, 1'($urandom));
    cycle(1'b0, 1'b1, b);
  endtask

  // Full frame; a good frame becomes one load, a bad-parity frame one error.
  task automatic send_frame(input logic [7:0] v, input int max_gap, input bit bad_par, input int trail);
    do_start(1'($urandom));
    for (int i = DATA_W - 1; i >= 0; i--) do_bit(v[i], int'($urandom_range(max_gap, 0)));
    if (PARITY) do_bit((^v) ^ bad_par, int'($urandom_range(max_gap, 0)));
    in_frame = 1'b0;
    if (PARITY && bad_par) begin
      exp_err++;
    end else begin
      exp_loads++;
      exp_cnt   = (exp_cnt + 1) % 256;
      exp_wdata = v;
    end
    idle(trail);
  endtask

  task automatic send_partial(input int k);
    do_start(1'($urandom));
    for (int i = 0; i < k; i++) do_bit(1'($urandom), 0);
  endtask

  task automatic check_model(input string tag);
    check({tag, " loads"}, wr_seen, exp_loads);
    check({tag, " errs"}, err_seen, exp_err);
    check({tag, " frame_cnt"}, bus.frame_cnt, exp_cnt);
    check({tag, " wdata"}, bus.wdata, exp_wdata);
  endtask

  initial begin
    logic [7:0] cnt_before;
    int         act;

    bus.sin_start = 1'b0;
    bus.sin_valid = 1'b0;
    bus.sin_bit   = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // 1: idle after reset
    idle(50);
    check("rst wr", bus.wr, 1'b0);
    check("rst busy", bus.busy, 1'b0);
    check("rst frame_err", bus.frame_err, 1'b0);
    check("rst frame_cnt", bus.frame_cnt, 8'h00);
    check("rst wdata", bus.wdata, 8'h00);

    // 2: 8'hA5 back-to-back, exact wr latency
    send_frame(8'hA5, 0, 1'b0, 0);
    idle(1);
    check("lat+1 wr", bus.wr, 1'b0);
    check("lat+1 busy", bus.busy, 1'b0);
    idle(1);
    check("lat+2 wr", bus.wr, 1'b1);
    check("lat+2 wdata", bus.wdata, 8'hA5);
    idle(1);
    check("lat+3 wr", bus.wr, 1'b0);
    check_model("a5");

    // 3: 8'h3C with 5-cycle gaps
    do_start(1'b1);
    for (int i = DATA_W - 1; i >= 0; i--) begin
      logic [7:0] v3 = 8'h3C;
      do_bit(v3[i], 5);
    end
    if (PARITY) do_bit(1'b0, 5);
    in_frame = 1'b0;
    exp_loads++;
    exp_cnt   = (exp_cnt + 1) % 256;
    exp_wdata = 8'h3C;
    check("gap busy", bus.busy, 1'b1);
    idle(4);
    check_model("3c gaps");

    // 4: timeout boundary after 4 bits
    send_partial(4);
    idle(TIMEOUT);
    check("tmo-1 busy", bus.busy, 1'b1);
    check("tmo-1 errs", err_seen, exp_err);
    idle(1);
    exp_err++;
    in_frame = 1'b0;
    check("tmo busy", bus.busy, 1'b0);
    check("tmo frame_err", bus.frame_err, 1'b1);
    idle(1);
    check("tmo pulse width", bus.frame_err, 1'b0);
    check_model("timeout");

    // 5: restart after 3 bits, then 8'h0F
    send_partial(3);
    send_frame(8'h0F, 2, 1'b0, 3);
    check_model("restart");

    // Restart in the cycle the last bit would arrive
    send_partial(FRAME_LEN - 1);
    send_frame(8'h5A, 0, 1'b0, 3);
    check_model("start beats last bit");

    // 6: reset mid-frame after 5 bits
    send_partial(5);
    @(negedge clk);
    #1;
    reset = 1'b1;
    bus.sin_start = 1'b0;
    bus.sin_valid = 1'b0;
    idle(1);
    check("midrst wdata", bus.wdata, 8'h00);
    check("midrst busy", bus.busy, 1'b0);
    check("midrst frame_cnt", bus.frame_cnt, 8'h00);
    reset     = 1'b0;
    in_frame  = 1'b0;
    exp_cnt   = 0;
    exp_wdata = 8'h00;
    idle(2);
    send_frame(8'hFF, 1, 1'b0, 3);
    check_model("after reset");

`ifdef PARITY_CHECK_EN
    // Bad parity: rejected, nothing loaded
    send_frame(8'hA5, 0, 1'b1, 3);
    check("bad parity busy", bus.busy, 1'b0);
    check_model("bad parity");
`endif

    // Randomized mix of good frames, timeouts and restarts
    for (int n = 0; n < 40; n++) begin
      act = int'($urandom_range(3, 0));
      if (act <= 1) begin
        send_frame(8'($urandom), TIMEOUT - 1, PARITY && ($urandom_range(3, 0) == 0), 3);
      end else if (act == 2) begin
        send_partial(int'($urandom_range(FRAME_LEN - 1, 0)));
        idle(TIMEOUT + 2);
        exp_err++;
        in_frame = 1'b0;
      end else begin
        send_partial(int'($urandom_range(FRAME_LEN - 1, 0)));
      end
    end
    send_frame(8'($urandom), 3, 1'b0, 3);
    check_model("random");

    // 256 loads wrap frame_cnt back to its starting value
    cnt_before = bus.frame_cnt;
    for (int n = 0; n < 256; n++) send_frame(8'($urandom), 0, 1'b0, 2);
    idle(2);
    check("wrap frame_cnt", bus.frame_cnt, cnt_before);
    check_model("wrap");

    check("wr/frame_err overlap", overlap, 0);
    check("wr spacing", spacing_bad, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
